matmul_operand_feeder: RTL
==========================

MATMUL_OPERAND_FEEDER -- requirements
Module: matmul_operand_feeder

Interface
REQ-001 Parameter VEC_BITS, default 2, log2 of the vector length V.
REQ-002 Parameter ROW_BITS, default 2, log2 of the matrix row count R.
REQ-003 Parameter COL_BITS, default 4, log2 of the matrix column count C.
REQ-004 Reset is rst_n, asynchronous, active-low; clock is clk.
REQ-005 Port list (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  host operand word valid
- in_data  in  16  host operand word
- in_ready  out  1  feeder accepts a word this cycle
- start  out  1  one-cycle start pulse to the engine
- eng_ready  in  1  engine idle (high in its READY state)
- sel_vec  in  VEC_BITS  engine vector index
- sel_row  in  ROW_BITS  engine matrix row index
- sel_col  in  COL_BITS  engine matrix column index
- data1  out  16  vector word at sel_vec
- data2  out  16  matrix word at (sel_row, sel_col)
- bank_full  out  2  per-bank full flags

Function
REQ-006 Two operand banks (0, 1); each holds V vector words and R*C matrix words.
REQ-007 Load side: wr_bank pointer plus word counter wr_cnt (0 .. V+R*C-1).
REQ-008 A word is accepted on a rising edge with in_valid && in_ready.
REQ-009 Word order per bank:
- vector 0..V-1 first;
- then matrix row-major: index V + row*C + col.
REQ-010 in_ready = !bank_full[wr_bank].
REQ-011 On accepting the last word (wr_cnt = V+R*C-1):
- set bank_full[wr_bank];
- reset wr_cnt to 0;
- toggle wr_bank, all in the same edge.
REQ-012 in_data when in_ready is low is ignored; storage and counters do not change.
REQ-013 Dispatch FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE; rd_bank pointer.
REQ-014 IDLE -> START when bank_full[rd_bank] && eng_ready; otherwise remain in IDLE.
REQ-015 START:
- start = 1 for exactly this one cycle;
- next state is WAIT_BUSY unconditionally.
REQ-016 WAIT_BUSY -> WAIT_DONE when eng_ready = 0.
REQ-017 WAIT_DONE -> IDLE when eng_ready = 1; on that edge clear bank_full[rd_bank] and toggle rd_bank.
REQ-018 data1 and data2 are combinational reads of bank rd_bank with zero latency; they are valid in every state.
REQ-019 Simultaneous events:
- a last-word load and a bank release in the same edge both take effect;
- they always target different banks, or the same bank with clear and set ordered by bank index; no flag is lost.
REQ-020 With both banks full, in_ready = 0 until a release occurs; the loader resumes the cycle after the release.
REQ-021 start is never asserted for a bank whose bank_full bit is 0.
REQ-022 Storage contents are not cleared on release; only the flags are cleared.

Reset
REQ-023 On rst_n low, immediately:
- state = IDLE, wr_bank = rd_bank = 0, wr_cnt = 0;
- bank_full = 2'b00, start = 0, in_ready = 1.
REQ-024 Storage contents are unspecified after reset; data1/data2 are don't-care until the first bank is full.
REQ-025 Reset mid-load or mid-compute discards all partial and full banks; no start is issued after reset until a complete bank is loaded again.

Verification
REQ-026 Load 68 words (vector 1,2,3,4; matrix all 1), eng_ready = 1:
- bank_full = 01 after the 68th word;
- start pulses once, one cycle after bank_full[0] rises.
REQ-027 After that load, drive sel_vec = 2, sel_row = 1, sel_col = 5:
- data1 = 3, data2 = 1, in the same cycle.
REQ-028 Load a second bank while the engine holds eng_ready = 0:
- bank_full = 11, in_ready = 0;
- when eng_ready rises, bank_full = 10, rd_bank = 1, in_ready = 1 next cycle;
- a second start follows.
REQ-029 Hold in_valid = 1 with both banks full for 10 cycles:
- wr_cnt does not change;
- the first word after release lands at bank 0 index 0.
REQ-030 Assert rst_n low after 30 words are loaded:
- bank_full = 00, wr_cnt = 0, in_ready = 1, start stays 0.
REQ-031 Final load word in the same cycle as the release of the other bank:
- bank_full transitions 01 -> 10 with no lost flag.

Source files
------------

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder
//   Purpose : double-buffered operand store for a matrix-vector engine. The
//             host streams V vector words then R*C matrix words (row-major)
//             into one bank while the engine reads the other bank.
//   Latency : data1/data2 are zero-latency combinational reads of rd_bank;
//             start pulses one cycle after the read bank becomes full.
//   Backpressure: in_ready drops while the write bank is still full (waiting
//             for the engine to release it); held words are ignored.
//   Ports   : clk, rst_n (async, active-low)
//             in_valid/in_data/in_ready : host load stream
//             start/eng_ready           : engine handshake
//             sel_vec/sel_row/sel_col   : engine read indices
//             data1/data2               : vector word / matrix word
//             bank_full                 : per-bank full flags
module matmul_operand_feeder #(
  parameter int VEC_BITS = 2,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [15:0]         in_data,
  output logic                in_ready,
  output logic                start,
  input  logic                eng_ready,
  input  logic [VEC_BITS-1:0] sel_vec,
  input  logic [ROW_BITS-1:0] sel_row,
  input  logic [COL_BITS-1:0] sel_col,
  output logic [15:0]         data1,
  output logic [15:0]         data2,
  output logic [1:0]          bank_full
);

  localparam int V       = 1 << VEC_BITS;
  localparam int RC_BITS = ROW_BITS + COL_BITS;
  localparam int MAT     = 1 << RC_BITS;
  localparam int WORDS   = V + MAT;
  localparam int CNT_W   = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [1:0]       r_bank_full;
  logic [15:0]      r_mem [2][WORDS];

  logic             w_accept;
  logic             w_last;
  logic             w_release;
  logic [1:0]       w_set;
  logic [1:0]       w_clr;
  logic [CNT_W-1:0] w_vec_addr;
  logic [CNT_W-1:0] w_mat_addr;

  assign in_ready  = !r_bank_full[r_wr_bank];
  assign bank_full = r_bank_full;
  assign start     = (r_state == START);

  assign w_accept  = in_valid && in_ready;
  assign w_last    = w_accept && (r_wr_cnt == LAST);
  assign w_release = (r_state == WAIT_DONE) && eng_ready;

  // Set and clear can land on the same edge; a load only completes into a
  // non-full bank and a release only frees a full bank, so they never
  // target the same flag.
  assign w_set = w_last    ? {r_wr_bank, ~r_wr_bank} : 2'b00;
  assign w_clr = w_release ? {r_rd_bank, ~r_rd_bank} : 2'b00;

  // Vector words sit at 0..V-1, matrix words follow at V + row*C + col.
  assign w_vec_addr = CNT_W'(sel_vec);
  assign w_mat_addr = CNT_W'(V) + CNT_W'({sel_row, sel_col});

  assign data1 = r_mem[r_rd_bank][w_vec_addr];
  assign data2 = r_mem[r_rd_bank][w_mat_addr];

  // Load-side pointers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
      if (w_accept) begin
        if (w_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  // Operand storage is deliberately not reset; release only drops the flag.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_bank][r_wr_cnt] <= in_data;
    end
  end

  // Dispatch state register and read-bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Engine handshake: wait for a full bank, pulse start, then see the
  // engine go busy (eng_ready low) and come back idle before releasing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (r_bank_full[r_rd_bank] && eng_ready) w_state_nxt = START;
      START:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!eng_ready) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (eng_ready) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

endmodule
